poly_addsub_stream: RTL

- Streaming polynomial coefficient adder/subtractor placed directly upstream of the Barrett reduction stage in the Kyber datapath.
- Accepts coefficient pairs (a, b) on a valid/ready handshake and computes a+b or a-b as int16.
- Counts N coefficients per polynomial and tags the frame boundary.
- Generates a valid/last strobe delayed to line up with the reducer's registered output, because the reducer has no enable.

---
 rtl/poly_addsub_stream.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/poly_addsub_stream.sv
// Streaming coefficient add/subtract stage ahead of the Barrett reducer.
// It has a two-entry output buffer (main + skid), per-frame last tagging, and a valid/last delay line aligned to the reducer.
module poly_addsub_stream #(
  parameter int unsigned N          = 256,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned REDUCE_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_coeff,
  output logic                    out_last,
  output logic                    red_valid,
  output logic                    red_last,
  output logic                    frame_done,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned XW = WIDTH + 1;

  // Registered state
  logic                  main_valid_q, main_valid_d;
  logic [WIDTH-1:0]      main_coeff_q, main_coeff_d;
  logic                  main_last_q,  main_last_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]      skid_coeff_q, skid_coeff_d;
  logic                  skid_last_q,  skid_last_d;
  logic                  in_ready_q,   in_ready_d;
  logic [CW-1:0]         idx_q,        idx_d;
  logic                  ovf_q,        ovf_d;
  logic                  frame_done_q, frame_done_d;
  logic [REDUCE_LAT-1:0] red_v_q,      red_v_d;
  logic [REDUCE_LAT-1:0] red_l_q,      red_l_d;

  // Handshake and arithmetic helpers
  logic          in_fire;
  logic          out_fire;
  logic [XW-1:0] ext_a;
  logic [XW-1:0] ext_b;
  logic [XW-1:0] sum;
  logic [WIDTH-1:0] res;
  logic          res_ovf;
  logic          res_last;

  // Sign-extend by one bit so the true result is always representable.
  always_comb begin : arith
    in_fire  = in_valid && in_ready_q;
    out_fire = main_valid_q && out_ready;
    ext_a    = {in_a[WIDTH-1], in_a};
    ext_b    = {in_b[WIDTH-1], in_b};
    sum      = op ? (ext_a - ext_b) : (ext_a + ext_b);
    res      = sum[WIDTH-1:0];
    res_ovf  = sum[WIDTH] ^ sum[WIDTH-1];
    res_last = (idx_q == CW'(N - 1));
  end

  // Next-state logic for buffer, counter, flags and delay line.
  always_comb begin : next_state
    main_valid_d = main_valid_q;
    main_coeff_d = main_coeff_q;
    main_last_d  = main_last_q;
    skid_valid_d = skid_valid_q;
    skid_coeff_d = skid_coeff_q;
    skid_last_d  = skid_last_q;
    idx_d        = idx_q;
    ovf_d        = ovf_q;
    frame_done_d = 1'b0;
    red_v_d      = REDUCE_LAT'({red_v_q, out_fire});
    red_l_d      = REDUCE_LAT'({red_l_q, out_fire && main_last_q});

    if (out_fire) begin
      frame_done_d = main_last_q;
      if (skid_valid_q) begin
        main_coeff_d = skid_coeff_q;
        main_last_d  = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // An accepted pair implies skid was empty, so after the pop above it
    // goes to main if main is free, otherwise into skid.
    if (in_fire) begin
      if (!main_valid_d) begin
        main_valid_d = 1'b1;
        main_coeff_d = res;
        main_last_d  = res_last;
      end else begin
        skid_valid_d = 1'b1;
        skid_coeff_d = res;
        skid_last_d  = res_last;
      end
      idx_d = res_last ? '0 : idx_q + CW'(1);
    end

    // A new overflow takes priority over a clear in the same cycle.
    if (in_fire && res_ovf) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  // State register
  always_ff @(posedge clk) begin : regs
    if (rst) begin
      main_valid_q <= 1'b0;
      main_coeff_q <= '0;
      main_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_coeff_q <= '0;
      skid_last_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      red_v_q      <= '0;
      red_l_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_coeff_q <= main_coeff_d;
      main_last_q  <= main_last_d;
      skid_valid_q <= skid_valid_d;
      skid_coeff_q <= skid_coeff_d;
      skid_last_q  <= skid_last_d;
      in_ready_q   <= in_ready_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
      red_v_q      <= red_v_d;
      red_l_q      <= red_l_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_coeff  = main_coeff_q;
  assign out_last   = main_last_q;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;
  assign red_valid  = red_v_q[REDUCE_LAT-1];
  assign red_last   = red_l_q[REDUCE_LAT-1];

endmodule
